// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-memory sequencer for the pipelined MIPS core.
// Turns load/store controls into a single outstanding req/ack bus transaction,
// stalls the pipeline while it is in flight and returns load data to writeback.
// Misaligned word accesses are flagged combinationally and never reach the bus.
// Optional feature: define DMEM_TIMEOUT_EN to abort a transaction that has
// waited TIMEOUT_CYCLES cycles without ack (bus_err_o pulse, rdata_o forced 0).
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef DMEM_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  // Without the timeout the counter is held at zero and never compared.
  localparam logic TO_EN = 1'b0;
`endif

  // Count value seen in the last permitted WAIT cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              idle_s;
  logic              misaligned_s;
  logic              start_s;
  logic              timeout_s;

  assign idle_s       = (state_q == S_IDLE);
  assign misaligned_s = (addr_i[1:0] != 2'b00);
  assign start_s      = memen_i & ~flush_i & ~misaligned_s & idle_s;
  assign timeout_s    = TO_EN & (cnt_q == CNT_LAST);

  assign stall_o = start_s | (state_q == S_WAIT);
  assign adel_o  = memen_i & ~memwrite_i & misaligned_s & idle_s;
  assign ades_o  = memen_i &  memwrite_i & misaligned_s & idle_s;

  assign bus_req_o   = req_q;
  assign bus_wr_o    = wr_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign bus_err_o   = err_q;

  // Next-state and next-output computation for the bus transaction sequencer.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          req_d   = 1'b1;
          wr_d    = memwrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Ack beats the timeout when both land on the same cycle.
        if (bus_ack_i) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          if (!wr_q) begin
            rdata_d = bus_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = S_DONE;
        end else if (timeout_s) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (TO_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // memen_i still belongs to the completed instruction here; ignore it.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases plus randomized load/store traffic,
// checked against a transaction-level model of stall length, bus contents,
// error reporting and the load data returned to writeback.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;   // 0 = no timeout in the model
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memen_i, memwrite_i, flush_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, adel_o, ades_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_wr_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES((TO == 0) ? 255 : TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .memen_i(memen_i), .memwrite_i(memwrite_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
    .bus_err_o(bus_err_o), .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One aligned load/store; ack arrives in WAIT cycle nwait+1 unless the
  // timeout fires first.
  task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] bus_rd, input int nwait, input logic flush_wait);
    int stalls;
    int waits;
    bit to_hit;
    to_hit = (TO != 0) && (nwait + 1 > TO);
    waits  = to_hit ? TO : nwait + 1;
    memen_i = 1'b1; memwrite_i = wr; addr_i = addr; wdata_i = wd;
    flush_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk_eq("issue_stall", stall_o, 1);
    chk_eq("issue_req", bus_req_o, 0);
    chk_eq("issue_adel", adel_o, 0);
    chk_eq("issue_ades", ades_o, 0);
    stalls = 1;
    for (int k = 1; k <= waits; k++) begin
      @(posedge clk); #1;
      flush_i     = flush_wait;
      bus_ack_i   = (!to_hit && k == waits);
      bus_rdata_i = (k == waits) ? bus_rd : $urandom;
      #1;
      chk_eq("wait_req", bus_req_o, 1);
      chk_eq("wait_wr", bus_wr_o, wr);
      chk_eq("wait_addr", bus_addr_o, addr);
      chk_eq("wait_wdata", bus_wdata_o, wd);
      chk_eq("wait_err", bus_err_o, 0);
      if (stall_o) stalls++;
    end
    @(posedge clk); #1;
    bus_ack_i = 1'b0; flush_i = 1'b0;
    if (to_hit) exp_rdata = 32'h0;
    else if (!wr) exp_rdata = bus_rd;
    #1;
    chk_eq("done_req", bus_req_o, 0);
    chk_eq("done_wr", bus_wr_o, 0);
    chk_eq("done_stall", stall_o, 0);
    chk_eq("done_rdata", rdata_o, exp_rdata);
    chk_eq("done_err", bus_err_o, to_hit);
    chk_eq("stall_cycles", stalls, waits + 1);
    memen_i = 1'b0;
    @(posedge clk); #1;
    chk_eq("idle_err", bus_err_o, 0);
    chk_eq("idle_req", bus_req_o, 0);
    chk_eq("idle_rdata", rdata_o, exp_rdata);
    chk_eq("idle_stall", stall_o, 0);
  endtask

  // Misaligned access: address error flag only, no bus traffic, no stall.
  task automatic do_misaligned(input logic wr, input logic [31:0] addr);
    memen_i = 1'b1; memwrite_i = wr; addr_i = addr; flush_i = 1'b0;
    #1;
    chk_eq("mis_adel", adel_o, !wr);
    chk_eq("mis_ades", ades_o, wr);
    chk_eq("mis_stall", stall_o, 0);
    @(posedge clk); #1;
    chk_eq("mis_req", bus_req_o, 0);
    chk_eq("mis_stall2", stall_o, 0);
    memen_i = 1'b0;
    #1;
    chk_eq("mis_clear", adel_o | ades_o, 0);
  endtask

  // Flushed access in IDLE: nothing issued.
  task automatic do_flush_idle(input logic wr, input logic [31:0] addr);
    memen_i = 1'b1; memwrite_i = wr; addr_i = addr; flush_i = 1'b1;
    #1;
    chk_eq("flush_stall", stall_o, 0);
    @(posedge clk); #1;
    chk_eq("flush_req", bus_req_o, 0);
    memen_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; memen_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h0000_0010;
    wdata_i = 32'h0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    exp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_req", bus_req_o, 0);
    chk_eq("rst_wr", bus_wr_o, 0);
    chk_eq("rst_err", bus_err_o, 0);
    chk_eq("rst_addr", bus_addr_o, 0);
    chk_eq("rst_wdata", bus_wdata_o, 0);
    chk_eq("rst_rdata", rdata_o, 0);
    memen_i = 1'b0;
    #1;
    chk_eq("rst_stall", stall_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mem(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    do_mem(1'b1, 32'h0000_0020, 32'h1234_5678, 32'hAAAA_5555, 3, 1'b0);
    do_misaligned(1'b0, 32'h0000_0013);
    do_misaligned(1'b1, 32'h0000_0002);
    do_flush_idle(1'b0, 32'h0000_0030);
    do_mem(1'b0, 32'h0000_0034, 32'h0, 32'h0BAD_F00D, 2, 1'b1);
    do_mem(1'b0, 32'h0000_0040, 32'h0, 32'h5A5A_A5A5, 10, 1'b0);
    do_mem(1'b0, 32'h0000_0044, 32'h0, 32'hC0FF_EE00, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind <= 5) begin
        a[1:0] = 2'b00;
        do_mem(1'($urandom_range(0, 1)), a, $urandom, $urandom,
               $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end else if (kind <= 7) begin
        a[1:0] = 2'($urandom_range(1, 3));
        do_misaligned(1'($urandom_range(0, 1)), a);
      end else if (kind == 8) begin
        do_flush_idle(1'($urandom_range(0, 1)), a);
      end else begin
        @(posedge clk); #1;
        chk_eq("idle_hold_rdata", rdata_o, exp_rdata);
      end
    end

    // Reset in the middle of a transaction abandons it.
    memen_i = 1'b1; memwrite_i = 1'b1; addr_i = 32'h0000_0100; wdata_i = 32'hFEED_0001;
    @(posedge clk); #1;
    chk_eq("mid_req_up", bus_req_o, 1);
    memen_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    chk_eq("mid_rst_req", bus_req_o, 0);
    chk_eq("mid_rst_wr", bus_wr_o, 0);
    chk_eq("mid_rst_stall", stall_o, 0);
    chk_eq("mid_rst_rdata", rdata_o, exp_rdata);
    do_mem(1'b0, 32'h0000_0104, 32'h0, 32'h7777_1234, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
